// File: rtl/wgt_buf_pkg.sv
// rtl/wgt_buf_pkg.sv - shared types and index helpers for the weight ping-pong buffer
package wgt_buf_pkg;

    typedef enum logic [0:0] {
        LD_LOAD = 1'b0,
        LD_FULL = 1'b1
    } wgt_ld_state_t;

    // Flat position of weight (ch,r,c); multiply by WGT_W for the bit offset.
    function automatic int wgt_idx(input int ch, input int r, input int c, input int ksize);
        return (ch * ksize + r) * ksize + c;
    endfunction

    function automatic int wgt_beats(input int num_ch, input int ksize);
        return num_ch * ksize;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wgt_row_unpack.sv
// rtl/wgt_row_unpack.sv - splits one packed kernel row into KSIZE weights, column 0 from the MS field
module wgt_row_unpack #(
    parameter int WGT_W = 8,
    parameter int KSIZE = 3
) (
    input  logic [KSIZE*WGT_W-1:0] row_in,
    output logic [KSIZE*WGT_W-1:0] row_out
);

    // Output is ordered by ascending column so it drops straight into the flat bank layout.
    for (genvar c = 0; c < KSIZE; c++) begin : g_col
        assign row_out[c*WGT_W +: WGT_W] = row_in[(KSIZE-1-c)*WGT_W +: WGT_W];
    end

endmodule

// File: rtl/wgt_pingpong_buf.sv
// rtl/wgt_pingpong_buf.sv - shadow/active weight bank pair; optional load_abort under WGT_BUF_ABORT_EN
module wgt_pingpong_buf
    import wgt_buf_pkg::*;
#(
    parameter int WGT_W  = 8,
    parameter int KSIZE  = 3,
    parameter int NUM_CH = 4,
    parameter int IN_W   = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [IN_W-1:0]                   in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              wgt_swap,
    output logic                              wgt_swap_ack,
    output logic                              wgt_valid,
`ifdef WGT_BUF_ABORT_EN
    input  logic                              load_abort,
`endif
    output logic [NUM_CH*KSIZE*KSIZE*WGT_W-1:0] wgt_out
);

    localparam int KW  = KSIZE * WGT_W;
    localparam int TOT = NUM_CH * KSIZE * KW;
    localparam int CW  = cnt_w(NUM_CH);
    localparam int RW  = cnt_w(KSIZE);

    if (IN_W < KW) begin : g_bad_in_w
        $error("wgt_pingpong_buf: IN_W must be at least KSIZE*WGT_W");
    end

    if (IN_W > KW) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^in_data[IN_W-1:KW];
    end

    logic          abort;
`ifdef WGT_BUF_ABORT_EN
    assign abort = load_abort;
`else
    assign abort = 1'b0;
`endif

    wgt_ld_state_t state;
    logic [CW-1:0] ch_cnt;
    logic [RW-1:0] row_cnt;
    logic [TOT-1:0] shadow;
    logic [TOT-1:0] active;
    logic [KW-1:0]  row;
    logic           accept;
    logic           last_beat;

    wgt_row_unpack #(
        .WGT_W (WGT_W),
        .KSIZE (KSIZE)
    ) u_unpack (
        .row_in  (in_data[KW-1:0]),
        .row_out (row)
    );

    // Abort suppresses both the beat handshake and the swap in the same cycle.
    assign in_ready     = !rst && !abort && (state == LD_LOAD);
    assign wgt_swap_ack = !rst && !abort && (state == LD_FULL) && wgt_swap;
    assign accept       = in_valid && in_ready;
    assign last_beat    = (ch_cnt == CW'(NUM_CH - 1)) && (row_cnt == RW'(KSIZE - 1));
    assign wgt_out      = active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LD_LOAD;
            ch_cnt    <= '0;
            row_cnt   <= '0;
            shadow    <= '0;
            active    <= '0;
            wgt_valid <= 1'b0;
        end else if (abort) begin
            state   <= LD_LOAD;
            ch_cnt  <= '0;
            row_cnt <= '0;
        end else begin
            if (accept) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    for (int r = 0; r < KSIZE; r++) begin
                        if (ch_cnt == CW'(ch) && row_cnt == RW'(r)) begin
                            shadow[wgt_idx(ch, r, 0, KSIZE)*WGT_W +: KW] <= row;
                        end
                    end
                end
                if (last_beat) begin
                    ch_cnt  <= '0;
                    row_cnt <= '0;
                    state   <= LD_FULL;
                end else if (row_cnt == RW'(KSIZE - 1)) begin
                    row_cnt <= '0;
                    ch_cnt  <= ch_cnt + 1'b1;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end
            if (wgt_swap_ack) begin
                active    <= shadow;
                wgt_valid <= 1'b1;
                state     <= LD_LOAD;
            end
        end
    end

endmodule

// File: doc/wgt_pingpong_buf.md
# wgt_pingpong_buf

Double-buffered, parametrised weight buffer feeding the PE array's kernel-weight inputs. Accepts packed kernel rows over a valid/ready stream into a shadow bank while the active bank drives all `NUM_CH` output-channel kernels. A level swap request from the layer controller copies the shadow bank into the active bank, so the next layer's or filter group's weights preload under compute.

## Interface
- `WGT_W`, default 8: signed weight width.
- `KSIZE`, default 3: kernel edge; each kernel has KSIZE*KSIZE weights.
- `NUM_CH`, default 4: output channels (kernels) held per bank.
- `IN_W`, default 32: load word width; must be ≥ KSIZE*WGT_W. Elaboration fails otherwise.

Ports (rst is synchronous and active-high; single clock clk):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `in_data` in IN_W: one kernel row, packed as described under Operation.
- `in_valid` in 1: in_data valid.
- `in_ready` out 1: the buffer accepts a beat.
- `wgt_swap` in 1: level request to promote the shadow bank to active; held until acknowledged.
- `wgt_swap_ack` out 1: swap accepted this cycle.
- `wgt_valid` out 1: the active bank holds a complete weight set.
- `wgt_out` out NUM_CH*KSIZE*KSIZE*WGT_W: active weights. Weight (ch,r,c) sits at flat index (ch*KSIZE+r)*KSIZE+c, times WGT_W.
- `load_abort` in 1: present only with WGT_BUF_ABORT_EN.

## Operation
- **Beat acceptance:** a beat is accepted when `in_valid && in_ready`.
- **Beat order:** channel-major, then row. Beat n maps to ch = n / KSIZE and r = n % KSIZE. A full bank is NUM_CH*KSIZE beats (12 at defaults).
- **Row unpack:** column c = `in_data[(KSIZE-1-c)*WGT_W +: WGT_W]`, so column 0 is the most-significant used field. Bits above KSIZE*WGT_W are ignored. There is no sign extension or truncation beyond the field select.
- **Load FSM states:** LOAD and FULL.
  - In LOAD, `in_ready` = 1, and row_cnt/ch_cnt advance per accepted beat. On the last beat, the counters wrap to 0 and the state goes to FULL.
  - In FULL, `in_ready` = 0 and beats are ignored.
- **Swap:** `wgt_swap_ack` = `wgt_swap && state==FULL`, combinational. On an ack cycle, at the clock edge:
  - the active bank takes the shadow bank;
  - `wgt_valid` is set to 1;
  - the state returns to LOAD.
- **Swap in LOAD:** a swap request while in LOAD is held pending without ack. The active bank and `wgt_valid` are unchanged.
- **Last beat and swap in the same cycle:** no ack that cycle. The ack comes the following cycle, provided `wgt_swap` is still high.
- **Active bank stability:** the active bank changes only on an ack. `wgt_out` is stable for any number of cycles between swaps.
- **Reset values:**
  - all shadow and active weights = 0;
  - `wgt_valid` = 0;
  - state LOAD, counters 0;
  - `wgt_swap_ack` = 0;
  - `in_ready` forced 0 while `rst` is high.
- **Reset mid-load:** discards the partial shadow contents. The next load restarts at beat 0.

## Timing
- Beat accepted at edge N: the shadow write is visible internally after edge N.
- Last beat at edge N: state is FULL from cycle N+1, and `in_ready` = 0 in cycle N+1.
- Ack in cycle M: new `wgt_out` and `wgt_valid` = 1 from edge M onward, visible in cycle M+1. `in_ready` = 1 in cycle M+1.
- Minimum load-to-use latency: NUM_CH*KSIZE accept cycles, plus 1 ack cycle.
- Back-to-back preload: a full shadow set can be reloaded under every active set. Throughput is 1 beat per cycle.

## Configuration
- **With `WGT_BUF_ABORT_EN`:** adds the `load_abort` input. When `load_abort` is high in LOAD or FULL:
  - the counters reset to 0 and the state goes to LOAD;
  - the shadow contents are considered invalid;
  - the active bank is untouched.
- **Abort priority:** `load_abort` has priority over a same-cycle beat and over a same-cycle swap. Neither is accepted, and the ack is forced to 0.
- **Without the macro:** the port is absent and the behaviour is as described above.

## Structure
- **Package `wgt_buf_pkg`:**
  - state enum `wgt_ld_state_t` {LD_LOAD, LD_FULL};
  - a function `wgt_idx(ch,r,c)` returning the flat weight index;
  - localparam helpers for the beat count.
- **Sub-module `wgt_row_unpack`:** parametrised on WGT_W and KSIZE. Splits one `in_data` word into KSIZE weights. It is instantiated once and its output is written into the shadow row selected by the counters.

## Test plan
- **Reset and idle:** after reset with no beats, `in_ready` = 1, `wgt_valid` = 0 and `wgt_out` = 0. Holding `wgt_swap` high gives no ack.
- **Full load and swap:** at defaults, send 12 beats where beat n = 0x00_(3n)_(3n+1)_(3n+2) low bytes, then assert swap. The ack arrives 1 cycle after the last beat. Weight (1,2,0) = 15, and `wgt_valid` = 1.
- **Backpressure:** send 12 beats, then a 13th with `in_valid` held high. `in_ready` = 0 and the 13th is not consumed until after the ack. It then lands as beat 0 of the next set, and the active weights are unchanged until the second swap.
- **Same-cycle last beat and swap:** `wgt_swap` is already high when the 12th beat is accepted. There is no ack in that cycle and the ack comes in the next. Negative weight 0x80 reads back as -128.
- **Reset mid-load:** pulse `rst` after 5 beats, then load 12 fresh beats and swap. All weights match the fresh data, with no stale values.
- **With WGT_BUF_ABORT_EN:** abort after 7 beats, together with a same-cycle `wgt_swap`. There is no ack, and the active bank holds its previous values. The following 12 beats load correctly.
